// File: rtl/psram_arb.sv
// psram_arb: shares one SPI PSRAM between an external SPI host (priority) and an internal master.
// Optional grant timeout is compiled in when PSRAM_ARB_TIMEOUT_EN is defined.
module psram_arb #(
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned MAX_GRANT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_csl,
  input  logic       host_sclk,
  input  logic       host_mosi,
  output logic       host_miso,
  input  logic       int_req,
  output logic       int_gnt,
  output logic       int_abort,
  input  logic       int_cs_n,
  input  logic       int_sclk,
  input  logic       int_mosi,
  output logic       int_miso,
  output logic       spi0_cs0,
  output logic       spi0_sclk,
  output logic       spi0_mosi,
  input  logic       spi0_miso,
  output logic       spi0_nwp,
  output logic       spi0_nhld,
  output logic [1:0] owner
);

  typedef enum logic [1:0] {
    StParkHost  = 2'b00,
    StGuardInt  = 2'b01,
    StInt       = 2'b10,
    StGuardHost = 2'b11
  } state_e;

  localparam logic [7:0] GuardLoad = 8'(GUARD_CYC - 1);

  if (GUARD_CYC < 1 || GUARD_CYC > 255 || MAX_GRANT < 2) begin : g_bad_param
    $error("psram_arb: GUARD_CYC must be 1..255 and MAX_GRANT at least 2");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hcs_meta_q, hcs_n_q;
  logic       gnt_q;
  logic       abort_q, abort_d;
  logic       grant_ok;
  logic       grant_expired;

  // host_csl is asynchronous to clk; only the synchronized copy steers the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcs_meta_q <= 1'b1;
      hcs_n_q    <= 1'b1;
      state_q    <= StParkHost;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      hcs_meta_q <= host_csl;
      hcs_n_q    <= hcs_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= (state_d == StInt);
      abort_q    <= abort_d;
    end
  end

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int unsigned GrantW = $clog2(MAX_GRANT + 1);

  logic [GrantW-1:0] gcnt_q, gcnt_d;
  logic              blk_q, blk_d;

  // Counter sits at zero outside INT, so it is already clear on every INT entry.
  always_comb begin
    gcnt_d        = (state_q == StInt) ? gcnt_q + GrantW'(1) : '0;
    grant_expired = (state_q == StInt) && (gcnt_q == GrantW'(MAX_GRANT - 1));
    blk_d         = blk_q;
    if (grant_expired && hcs_n_q && int_req) begin
      blk_d = 1'b1;
    end else if (!int_req) begin
      blk_d = 1'b0;
    end
    grant_ok = !blk_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt_q <= '0;
      blk_q  <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      blk_q  <= blk_d;
    end
  end
`else
  assign grant_expired = 1'b0;
  assign grant_ok      = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    case (state_q)
      StParkHost: begin
        if (int_req && hcs_n_q && grant_ok) begin
          state_d = StGuardInt;
          cnt_d   = GuardLoad;
        end
      end
      StGuardInt: begin
        if (!hcs_n_q) begin
          state_d = StParkHost;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (!int_req) begin
          // Request withdrawn before any internal traffic: bus is idle, hand it straight back.
          state_d = StParkHost;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StInt;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StInt: begin
        if (!hcs_n_q) begin
          state_d = StParkHost;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (!int_req) begin
          state_d = StGuardHost;
          cnt_d   = GuardLoad;
        end else if (grant_expired) begin
          state_d = StGuardHost;
          cnt_d   = GuardLoad;
          abort_d = 1'b1;
        end
      end
      StGuardHost: begin
        if (!hcs_n_q || cnt_q == '0) begin
          state_d = StParkHost;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StParkHost;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin routing is purely combinational so neither SPI clock ever passes through a flop.
  always_comb begin
    spi0_cs0  = 1'b1;
    spi0_sclk = 1'b0;
    spi0_mosi = 1'b0;
    case (state_q)
      StParkHost: begin
        spi0_cs0  = host_csl;
        spi0_sclk = host_sclk;
        spi0_mosi = host_mosi;
      end
      StInt: begin
        spi0_cs0  = int_cs_n;
        spi0_sclk = int_sclk;
        spi0_mosi = int_mosi;
      end
      default: begin
        spi0_cs0  = 1'b1;
        spi0_sclk = 1'b0;
        spi0_mosi = 1'b0;
      end
    endcase
  end

  assign host_miso = spi0_miso;
  assign int_miso  = spi0_miso;
  assign spi0_nwp  = 1'b1;
  assign spi0_nhld = 1'b1;
  assign int_gnt   = gnt_q;
  assign int_abort = abort_q;
  assign owner     = state_q;

endmodule

// File: tb/tb_psram_arb.sv
// tb_psram_arb: directed scenarios plus randomized run against a behavioural arbitration model.
// A tiny SPI PSRAM model answers 0x9F (ID) and 0x03 (read) on the shared pins.
module tb_psram_arb;

  localparam int unsigned Guard    = 4;
  localparam int unsigned MaxGrant = 16;
  localparam int          SpiHalf  = 17;
  localparam logic [31:0] PsId     = 32'h0D5D_0000;

  logic       clk = 1'b0;
  logic       rst_n, host_csl, host_sclk, host_mosi, host_miso;
  logic       int_req, int_gnt, int_abort, int_cs_n, int_sclk, int_mosi, int_miso;
  logic       spi0_cs0, spi0_sclk, spi0_mosi, spi0_miso, spi0_nwp, spi0_nhld;
  logic [1:0] owner;

  int n_chk  = 0;
  int n_fail = 0;

  psram_arb #(
    .GUARD_CYC(Guard),
    .MAX_GRANT(MaxGrant)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host_csl (host_csl),
    .host_sclk(host_sclk),
    .host_mosi(host_mosi),
    .host_miso(host_miso),
    .int_req  (int_req),
    .int_gnt  (int_gnt),
    .int_abort(int_abort),
    .int_cs_n (int_cs_n),
    .int_sclk (int_sclk),
    .int_mosi (int_mosi),
    .int_miso (int_miso),
    .spi0_cs0 (spi0_cs0),
    .spi0_sclk(spi0_sclk),
    .spi0_mosi(spi0_mosi),
    .spi0_miso(spi0_miso),
    .spi0_nwp (spi0_nwp),
    .spi0_nhld(spi0_nhld),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // PSRAM model: mode-0 SPI slave, shifts in on rising sclk, drives out on falling sclk.
  int          ps_cnt;
  logic [31:0] ps_hdr, ps_sh;
  logic        ps_miso;
  assign spi0_miso = ps_miso;

  initial begin
    ps_cnt = 0; ps_hdr = '0; ps_sh = '0; ps_miso = 1'b0;
    forever begin
      @(posedge spi0_sclk or posedge spi0_cs0);
      if (spi0_cs0) begin
        ps_cnt = 0;
      end else begin
        ps_hdr = {ps_hdr[30:0], spi0_mosi};
        ps_cnt++;
        if (ps_cnt == 8 && ps_hdr[7:0] == 8'h9F) ps_sh = PsId;
        else if (ps_cnt == 32 && ps_hdr[31:24] == 8'h03) ps_sh = {ps_hdr[7:0] ^ 8'h5A, 24'h0};
      end
    end
  end

  initial begin
    forever begin
      @(negedge spi0_sclk);
      if (!spi0_cs0 && ps_cnt >= 8) begin
        ps_miso = ps_sh[31];
        ps_sh   = {ps_sh[30:0], 1'b0};
      end
    end
  end

  task automatic spi_txn(input bit use_int, input logic [7:0] cmd, input logic [23:0] addr,
                         input int addr_bits, input int rd_bits, output logic [31:0] rd);
    logic [31:0] hdr;
    logic        b;
    hdr = {cmd, addr};
    rd  = '0;
    if (use_int) int_cs_n = 1'b0; else host_csl = 1'b0;
    #SpiHalf;
    for (int i = 0; i < 8 + addr_bits + rd_bits; i++) begin
      b = (i < 8 + addr_bits) ? hdr[31 - i] : 1'b0;
      if (use_int) int_mosi = b; else host_mosi = b;
      #SpiHalf;
      if (i >= 8 + addr_bits) rd = {rd[30:0], use_int ? int_miso : host_miso};
      if (use_int) int_sclk = 1'b1; else host_sclk = 1'b1;
      #SpiHalf;
      if (use_int) int_sclk = 1'b0; else host_sclk = 1'b0;
    end
    #SpiHalf;
    if (use_int) begin int_cs_n = 1'b1; int_mosi = 1'b0; end
    else begin host_csl = 1'b1; host_mosi = 1'b0; end
  endtask

  // Behavioural model: owner code, guard cycles remaining, INT cycles served, block flag.
  int m_owner, m_left, m_gcyc;
  bit m_abort, m_blk, m_s1, m_s2;

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_gcyc = 0; m_abort = 0; m_blk = 0; m_s1 = 1; m_s2 = 1;
  endtask

  task automatic model_step();
    bit hcs;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hcs = m_s2;
    m_s2 = m_s1;
    m_s1 = host_csl;
    m_abort = 0;
    case (m_owner)
      0: if (int_req && hcs && !m_blk) begin m_owner = 1; m_left = Guard; end
      1: begin
        if (!hcs) begin m_owner = 0; m_abort = 1; end
        else if (!int_req) m_owner = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_owner = 2; m_gcyc = 0; end
        end
      end
      2: begin
        if (!hcs) begin m_owner = 0; m_abort = 1; end
        else if (!int_req) begin m_owner = 3; m_left = Guard; end
        else begin
          m_gcyc++;
`ifdef PSRAM_ARB_TIMEOUT_EN
          if (m_gcyc == MaxGrant) begin
            m_owner = 3; m_left = Guard; m_abort = 1; m_blk = 1;
          end
`endif
        end
      end
      default: begin
        if (!hcs) m_owner = 0;
        else begin
          m_left--;
          if (m_left == 0) m_owner = 0;
        end
      end
    endcase
    if (!int_req) m_blk = 0;
  endtask

  logic [31:0] rd;
  logic [23:0] addr;
  int          cnt, bad, int_cyc;
  bit          saw_abort;
  logic [2:0]  exp_route;

  initial begin
    rst_n = 1'b0; host_csl = 1'b1; host_sclk = 1'b0; host_mosi = 1'b0;
    int_req = 1'b0; int_cs_n = 1'b1; int_sclk = 1'b0; int_mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {owner, int_gnt, int_abort}, 4'b0000);
    check("wp_hold", {spi0_nwp, spi0_nhld}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;

    // Host path idle ownership and passthrough.
    @(negedge clk);
    host_csl = 1'b0; #1;
    check("cs_follow_lo", spi0_cs0, 1'b0);
    host_csl = 1'b1; #1;
    check("cs_follow_hi", spi0_cs0, 1'b1);
    spi_txn(1'b0, 8'h9F, 24'h0, 0, 16, rd);
    check("host_read_id", rd, PsId[31:16]);
    check("host_owner", owner, 2'd0);
    repeat (3) @(negedge clk);

    // Internal request with idle host: Guard cycles of CS high, grant on the next edge.
    int_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k <= 4) check("guard_int", {owner, int_gnt, spi0_cs0}, {2'd1, 1'b0, 1'b1});
      else check("grant", {owner, int_gnt}, {2'd2, 1'b1});
    end
    addr = 24'($urandom);
    spi_txn(1'b1, 8'h03, addr, 24, 8, rd);
    check("int_read", rd, {24'h0, addr[7:0] ^ 8'h5A});

    // Host preempts: one abort pulse, host owns the bus within three clocks.
    @(negedge clk);
    host_csl = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      cnt += int'(int_abort);
      if (k == 3) check("preempt", {owner, int_gnt}, {2'd0, 1'b0});
    end
    check("abort_pulses", cnt, 1);

    // Request pending while host is active: no grant until host releases.
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (owner != 2'd0 || int_gnt) bad++;
    end
    check("pending_hold", bad, 0);
    @(negedge clk);
    host_csl = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) check("regrant_early", int_gnt, 1'b0);
      if (k == 7) check("regrant", int_gnt, 1'b1);
    end

    // Short reset mid-INT.
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_int", {owner, int_gnt, int_abort}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; int_req = 1'b0;
    repeat (3) @(negedge clk);

    // Grant length limit.
    int_req = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!int_gnt && cnt < 20);
    check("long_grant", int_gnt, 1'b1);
`ifdef PSRAM_ARB_TIMEOUT_EN
    int_cyc = 1;
    saw_abort = 0;
    for (int k = 0; k < 100 && !saw_abort; k++) begin
      @(posedge clk); #1;
      if (int_abort) saw_abort = 1;
      else if (owner == 2'd2) int_cyc++;
    end
    check("timeout_abort", saw_abort, 1'b1);
    check("timeout_len", int_cyc, MaxGrant);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (owner == 2'd1 || owner == 2'd2) bad++;
    end
    check("timeout_block", bad, 0);
    @(negedge clk);
    int_req = 1'b0;
    @(negedge clk);
    int_req = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!int_gnt && cnt < 20);
    check("timeout_regrant", int_gnt, 1'b1);
`else
    bad = 0;
    repeat (10000) begin
      @(posedge clk); #1;
      if (int_abort || !int_gnt) bad++;
    end
    check("no_timeout", bad, 0);
`endif

    // Randomized run against the model, with occasional resets.
    @(negedge clk);
    rst_n = 1'b0; int_req = 1'b0; host_csl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 23) == 0) int_req = ~int_req;
      if ($urandom_range(0, 29) == 0) host_csl = ~host_csl;
      host_sclk = 1'($urandom); host_mosi = 1'($urandom);
      int_cs_n = 1'($urandom); int_sclk = 1'($urandom); int_mosi = 1'($urandom);
      @(posedge clk);
      model_step();
      #1;
      check("rnd_state", {owner, int_gnt, int_abort},
            {2'(m_owner), (m_owner == 2), m_abort});
      if (m_owner == 0) exp_route = {host_csl, host_sclk, host_mosi};
      else if (m_owner == 2) exp_route = {int_cs_n, int_sclk, int_mosi};
      else exp_route = 3'b100;
      check("rnd_route", {spi0_cs0, spi0_sclk, spi0_mosi}, exp_route);
      check("rnd_miso", {host_miso, int_miso}, {spi0_miso, spi0_miso});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
